alu_operand_stage: RTL

- Registered operand-delivery stage directly upstream of the CLA add/sub unit; it drives that unit's Rs1, Rs2, En and funct7_5 inputs.
- Accepts decoded ALU ops from decode through a valid/ready handshake and buffers them in a 2-entry skid buffer (output entry O plus skid entry S).
- Resolves register hazards by forwarding from the MEM and WB stages. Forwarding is applied both when an op is captured and while an op is held in the buffer.

---
 rtl/alu_operand_stage.sv | 124 ++++++++++++
 1 files changed

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: 2-entry skid-buffered operand stage with MEM/WB forwarding feeding the CLA add/sub unit.
// Optional immediate operand select is enabled by defining ALU_IMM_SEL_EN.
module alu_operand_stage #(
    parameter int WIDTH  = 32,
    parameter int REG_AW = 5
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              flush,
    input  logic              dec_valid,
    output logic              dec_ready,
    input  logic [WIDTH-1:0]  dec_rs1_data,
    input  logic [WIDTH-1:0]  dec_rs2_data,
    input  logic [REG_AW-1:0] dec_rs1_addr,
    input  logic [REG_AW-1:0] dec_rs2_addr,
    input  logic [REG_AW-1:0] dec_rd_addr,
    input  logic              dec_funct7_5,
    input  logic              dec_alu_en,
`ifdef ALU_IMM_SEL_EN
    input  logic [WIDTH-1:0]  dec_imm,
    input  logic              dec_use_imm,
`endif
    input  logic              fwd_mem_we,
    input  logic [REG_AW-1:0] fwd_mem_rd,
    input  logic [WIDTH-1:0]  fwd_mem_data,
    input  logic              fwd_wb_we,
    input  logic [REG_AW-1:0] fwd_wb_rd,
    input  logic [WIDTH-1:0]  fwd_wb_data,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [WIDTH-1:0]  Rs1,
    output logic [WIDTH-1:0]  Rs2,
    output logic              En,
    output logic              funct7_5,
    output logic [REG_AW-1:0] ex_rd_addr
);
    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] a1;
        logic [REG_AW-1:0] a2;
        logic [REG_AW-1:0] rd;
        logic [WIDTH-1:0]  d1;
        logic [WIDTH-1:0]  d2;
        logic              f7;
        logic              en;
        logic              imm;
    } entry_t;

    entry_t o_q, o_d, s_q, s_d, in_e;
    logic   acc;

    // MEM beats WB beats the current value; x0 never matches
    function automatic logic [WIDTH-1:0] fwd(input logic [REG_AW-1:0] a, input logic [WIDTH-1:0] d);
        fwd = (fwd_mem_we && fwd_mem_rd != '0 && fwd_mem_rd == a) ? fwd_mem_data :
              (fwd_wb_we && fwd_wb_rd != '0 && fwd_wb_rd == a) ? fwd_wb_data : d;
    endfunction

    function automatic entry_t snoop(input entry_t e);
        snoop    = e;
        snoop.d1 = fwd(e.a1, e.d1);
        snoop.d2 = e.imm ? e.d2 : fwd(e.a2, e.d2);
    endfunction

    assign dec_ready  = !s_q.v && !rst;
    assign acc        = dec_valid && dec_ready;
    assign ex_valid   = o_q.v;
    assign Rs1        = o_q.d1;
    assign Rs2        = o_q.d2;
    assign En         = o_q.v && o_q.en;
    assign funct7_5   = o_q.f7;
    assign ex_rd_addr = o_q.rd;

    always_comb begin
        in_e.v   = 1'b1;
        in_e.a1  = dec_rs1_addr;
        in_e.a2  = dec_rs2_addr;
        in_e.rd  = dec_rd_addr;
        in_e.d1  = fwd(dec_rs1_addr, dec_rs1_data);
        in_e.d2  = fwd(dec_rs2_addr, dec_rs2_data);
        in_e.f7  = dec_funct7_5;
        in_e.en  = dec_alu_en;
        in_e.imm = 1'b0;
`ifdef ALU_IMM_SEL_EN
        if (dec_use_imm) begin
            in_e.d2  = dec_imm;
            in_e.f7  = 1'b0;
            in_e.imm = 1'b1;
        end
`endif
    end

    // Data of an empty O is left untouched so outputs hold while ex_valid=0
    always_comb begin
        o_d = o_q;
        s_d = s_q;
        if (flush) begin
            o_d.v = 1'b0;
            s_d.v = 1'b0;
        end else if (!o_q.v || ex_ready) begin
            if (s_q.v) begin
                o_d   = snoop(s_q);
                s_d.v = 1'b0;
            end else if (acc) begin
                o_d = in_e;
            end else begin
                o_d.v = 1'b0;
            end
        end else begin
            o_d = snoop(o_q);
            if (acc) s_d = in_e;
            else if (s_q.v) s_d = snoop(s_q);
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            o_q <= '0;
            s_q <= '0;
        end else begin
            o_q <= o_d;
            s_q <= s_d;
        end
    end
endmodule
